// File: rtl/sclk_pattern_stepper_pkg.sv
// Shared types and constants for the SCLK pattern stepper.
// State encoding, mode and direction codes.
package stepper_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;
  localparam logic DIR_LEFT    = 1'b0;
  localparam logic DIR_RIGHT   = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_LOAD = ST_LOAD,
    S_RUN  = ST_RUN
  } state_e;

endpackage

// File: rtl/sclk_pattern_stepper_if.sv
// Bundle of stepper controls (master drives) and status (slave drives).
// SCLK/load_req/pattern_in/run_en/mode/dir in; LED/load_done/step_count out.
interface sclk_pattern_stepper_if #(
  parameter int WIDTH = 16
);
  logic             SCLK;
  logic             load_req;
  logic [WIDTH-1:0] pattern_in;
  logic             run_en;
  logic             mode;
  logic             dir;
  logic [WIDTH-1:0] LED;
  logic             load_done;
  logic [15:0]      step_count;

  modport master (
    output SCLK, load_req, pattern_in,
    output run_en, mode, dir,
    input  LED, load_done, step_count
  );

  modport slave (
    input  SCLK, load_req, pattern_in,
    input  run_en, mode, dir,
    output LED, load_done, step_count
  );
endinterface

// File: rtl/sclk_pattern_stepper_sync_edge_detect.sv
// Synchronizer chain plus registered rising-edge detector.
// Ports: CLK, CPU_RESETN, async_in -> rise_pulse (one CLK wide).
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic CPU_RESETN,
  input  logic async_in,
  output logic rise_pulse
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign rise_pulse = rise_q;
endmodule

// File: rtl/sclk_pattern_stepper.sv
// LED pattern stepper advanced by edges of an asynchronous slow SCLK.
// Ports: CLK, CPU_RESETN, bus (slave): controls in, LED/status out.
module sclk_pattern_stepper
  import stepper_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic CPU_RESETN,
  sclk_pattern_stepper_if.slave bus
);
  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic             dir_q;
  logic [15:0]      cnt_q;
  logic             done_q;

  logic             tick;
  logic             load_pulse;
  logic [WIDTH-1:0] step_d;
  logic             dir_d;
  logic [WIDTH-1:0] load_d;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .CLK        (CLK),
    .CPU_RESETN (CPU_RESETN),
    .async_in   (bus.SCLK),
    .rise_pulse (tick)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_load (
    .CLK        (CLK),
    .CPU_RESETN (CPU_RESETN),
    .async_in   (bus.load_req),
    .rise_pulse (load_pulse)
  );

  // An all-zero load would leave nothing to move; seed bit 0.
  assign load_d = (bus.pattern_in == '0)
                ? {{(WIDTH-1){1'b0}}, 1'b1}
                : bus.pattern_in;

  // Bounce reverses instead of shifting the end bit out.
  always_comb begin
    step_d = shreg_q;
    dir_d  = dir_q;
    unique case (1'b1)
      bus.mode == MODE_ROTATE && dir_q == DIR_LEFT:
        step_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
      bus.mode == MODE_ROTATE && dir_q == DIR_RIGHT:
        step_d = {shreg_q[0], shreg_q[WIDTH-1:1]};
      bus.mode == MODE_BOUNCE && dir_q == DIR_LEFT:
        if (shreg_q[WIDTH-1]) begin
          dir_d  = DIR_RIGHT;
          step_d = shreg_q >> 1;
        end else begin
          step_d = shreg_q << 1;
        end
      default:
        if (shreg_q[0]) begin
          dir_d  = DIR_LEFT;
          step_d = shreg_q << 1;
        end else begin
          step_d = shreg_q >> 1;
        end
    endcase
  end

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      dir_q   <= DIR_LEFT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (load_pulse) state_q <= S_LOAD;
        end
        S_LOAD: begin
          shreg_q <= load_d;
          dir_q   <= bus.dir;
          cnt_q   <= '0;
          done_q  <= 1'b1;
          state_q <= S_RUN;
        end
        S_RUN: begin
          // A reload in the same cycle as a tick swallows the tick.
          if (load_pulse) begin
            state_q <= S_LOAD;
          end else if (tick && bus.run_en) begin
            shreg_q <= step_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.LED        = shreg_q;
  assign bus.load_done  = done_q;
  assign bus.step_count = cnt_q;
endmodule

// File: tb/tb_sclk_pattern_stepper.sv
// Randomized self-checking bench for sclk_pattern_stepper.
// Reference model works per SCLK rise / load, not per clock.
module tb_sclk_pattern_stepper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sclk_pattern_stepper_if #(.WIDTH(16)) bus ();

  sclk_pattern_stepper #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .CLK        (clk),
    .CPU_RESETN (rst_n),
    .bus        (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] m_led;
  logic [15:0] m_cnt;
  logic        m_dir;
  logic        m_loaded;
  logic        m_run;
  logic        m_mode;

  task automatic m_reset();
    m_led = 16'h0; m_cnt = 16'h0;
    m_dir = 1'b0; m_loaded = 1'b0;
  endtask

  task automatic m_load(input logic [15:0] p, input logic d);
    m_led = (p == 16'h0) ? 16'h0001 : p;
    m_dir = d; m_cnt = 16'h0; m_loaded = 1'b1;
  endtask

  task automatic m_tick();
    if (!m_loaded || !m_run) return;
    m_cnt = m_cnt + 16'd1;
    if (!m_mode) begin
      if (!m_dir) m_led = (m_led << 1) | (m_led >> 15);
      else        m_led = (m_led >> 1) | (m_led << 15);
    end else if (!m_dir) begin
      if (m_led[15]) begin m_dir = 1'b1; m_led = m_led >> 1; end
      else m_led = m_led << 1;
    end else begin
      if (m_led[0]) begin m_dir = 1'b0; m_led = m_led << 1; end
      else m_led = m_led >> 1;
    end
  endtask

  task automatic set_ctl(input logic run, input logic md);
    bus.run_en = run; bus.mode = md;
    m_run = run; m_mode = md;
  endtask

  task automatic sclk_pulse();
    @(negedge clk) bus.SCLK = 1'b1;
    repeat (6) @(negedge clk);
    bus.SCLK = 1'b0;
    repeat (6) @(negedge clk);
    m_tick();
  endtask

  task automatic do_load(input logic [15:0] p, input logic d);
    @(negedge clk);
    bus.pattern_in = p; bus.dir = d; bus.load_req = 1'b1;
    repeat (6) @(negedge clk);
    bus.load_req = 1'b0;
    repeat (6) @(negedge clk);
    m_load(p, d);
  endtask

  task automatic test_reset();
    m_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.LED !== 16'h0) begin
      errors++; $display("FAIL reset_led: got %h want 0000", bus.LED);
    end
    checks++;
    if (bus.load_done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b want 0", bus.load_done);
    end
    checks++;
    if (bus.step_count !== 16'h0) begin
      errors++; $display("FAIL reset_cnt: got %h want 0000", bus.step_count);
    end
    rst_n = 1'b1;
    set_ctl(1'b1, 1'b0);
    sclk_pulse();
    checks++;
    if (bus.LED !== m_led || bus.load_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_tick: got led %h done %b want %h 0",
               bus.LED, bus.load_done, m_led);
    end
  endtask

  task automatic test_rotate();
    logic [15:0] exp_tab [3];
    exp_tab[0] = 16'h0002; exp_tab[1] = 16'h0004; exp_tab[2] = 16'h0008;
    set_ctl(1'b1, 1'b0);
    do_load(16'h0001, 1'b0);
    checks++;
    if (bus.load_done !== 1'b1 || bus.LED !== 16'h0001) begin
      errors++;
      $display("FAIL rot_load: got led %h done %b want 0001 1",
               bus.LED, bus.load_done);
    end
    for (int i = 0; i < 3; i++) begin
      sclk_pulse();
      checks++;
      if (bus.LED !== exp_tab[i] || bus.LED !== m_led) begin
        errors++;
        $display("FAIL rot_step%0d: got %h want %h", i, bus.LED, exp_tab[i]);
      end
    end
    checks++;
    if (bus.step_count !== 16'd3) begin
      errors++; $display("FAIL rot_cnt: got %0d want 3", bus.step_count);
    end
  endtask

  task automatic test_zero_wrap();
    set_ctl(1'b1, 1'b0);
    do_load(16'h0000, 1'b1);
    checks++;
    if (bus.LED !== 16'h0001) begin
      errors++; $display("FAIL zero_load: got %h want 0001", bus.LED);
    end
    sclk_pulse();
    checks++;
    if (bus.LED !== 16'h8000) begin
      errors++; $display("FAIL zero_first: got %h want 8000", bus.LED);
    end
    repeat (15) sclk_pulse();
    checks++;
    if (bus.LED !== 16'h0001 || bus.step_count !== 16'd16) begin
      errors++;
      $display("FAIL zero_wrap: got led %h cnt %0d want 0001 16",
               bus.LED, bus.step_count);
    end
  endtask

  task automatic test_bounce();
    logic [15:0] a [3];
    logic [15:0] b [3];
    a[0] = 16'h8000; a[1] = 16'h4000; a[2] = 16'h2000;
    b[0] = 16'h0001; b[1] = 16'h0002; b[2] = 16'h0004;
    set_ctl(1'b1, 1'b1);
    do_load(16'h4000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sclk_pulse();
      checks++;
      if (bus.LED !== a[i] || bus.LED !== m_led) begin
        errors++;
        $display("FAIL bounce_hi%0d: got %h want %h", i, bus.LED, a[i]);
      end
    end
    do_load(16'h0002, 1'b1);
    for (int i = 0; i < 3; i++) begin
      sclk_pulse();
      checks++;
      if (bus.LED !== b[i] || bus.LED !== m_led) begin
        errors++;
        $display("FAIL bounce_lo%0d: got %h want %h", i, bus.LED, b[i]);
      end
    end
  endtask

  task automatic test_hold_latency();
    logic [15:0] led0, cnt0;
    led0 = m_led; cnt0 = m_cnt;
    set_ctl(1'b0, 1'b0);
    repeat (5) sclk_pulse();
    checks++;
    if (bus.LED !== led0 || bus.step_count !== cnt0) begin
      errors++;
      $display("FAIL hold: got led %h cnt %h want %h %h",
               bus.LED, bus.step_count, led0, cnt0);
    end
    set_ctl(1'b1, 1'b0);
    @(negedge clk) bus.SCLK = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.LED !== led0) begin
      errors++; $display("FAIL lat_early: got %h want %h", bus.LED, led0);
    end
    @(negedge clk);
    m_tick();
    checks++;
    if (bus.LED !== m_led) begin
      errors++; $display("FAIL lat_edge: got %h want %h", bus.LED, m_led);
    end
    bus.SCLK = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (bus.LED !== m_led || bus.step_count !== m_cnt) begin
      errors++;
      $display("FAIL fall_edge: got %h %h want %h %h",
               bus.LED, bus.step_count, m_led, m_cnt);
    end
  endtask

  task automatic test_collision();
    set_ctl(1'b1, 1'b0);
    @(negedge clk);
    bus.pattern_in = 16'h00F0; bus.dir = 1'b0;
    bus.load_req = 1'b1; bus.SCLK = 1'b1;
    repeat (6) @(negedge clk);
    bus.load_req = 1'b0; bus.SCLK = 1'b0;
    repeat (6) @(negedge clk);
    m_load(16'h00F0, 1'b0);
    checks++;
    if (bus.LED !== 16'h00F0 || bus.step_count !== 16'h0) begin
      errors++;
      $display("FAIL collide: got led %h cnt %0d want 00f0 0",
               bus.LED, bus.step_count);
    end
    sclk_pulse();
    checks++;
    if (bus.LED !== 16'h01E0) begin
      errors++; $display("FAIL collide_next: got %h want 01e0", bus.LED);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    checks++;
    if (bus.LED !== 16'h0 || bus.load_done !== 1'b0 ||
        bus.step_count !== 16'h0) begin
      errors++;
      $display("FAIL async_rst: got led %h done %b cnt %h want 0 0 0",
               bus.LED, bus.load_done, bus.step_count);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) sclk_pulse();
    checks++;
    if (bus.LED !== 16'h0 || bus.load_done !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_tick: got led %h done %b want 0 0",
               bus.LED, bus.load_done);
    end
  endtask

  task automatic test_random();
    logic [15:0] p;
    int act;
    do_load(16'h1234, 1'b0);
    for (int i = 0; i < 60; i++) begin
      act = $urandom_range(0, 9);
      bus.dir = 1'($urandom);
      if (act == 0) begin
        p = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        do_load(p, 1'($urandom));
      end else begin
        set_ctl(($urandom_range(0, 4) != 0), 1'($urandom));
        sclk_pulse();
      end
      checks++;
      if (bus.LED !== m_led || bus.step_count !== m_cnt ||
          bus.load_done !== m_loaded) begin
        errors++;
        $display("FAIL rand%0d: got %h %h %b want %h %h %b", i,
                 bus.LED, bus.step_count, bus.load_done,
                 m_led, m_cnt, m_loaded);
      end
    end
  endtask

  initial begin
    bus.SCLK = 1'b0; bus.load_req = 1'b0;
    bus.pattern_in = 16'h0; bus.run_en = 1'b0;
    bus.mode = 1'b0; bus.dir = 1'b0;
    m_run = 1'b0; m_mode = 1'b0;
    test_reset();
    test_rotate();
    test_zero_wrap();
    test_bounce();
    test_hold_latency();
    test_collision();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
